// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared ALU operation codes and M-extension types
package alu_ctrl_pkg;

    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_OR      = 4'b0001;
    localparam logic [3:0] OP_ADD     = 4'b0010;
    localparam logic [3:0] OP_SRA     = 4'b0100;
    localparam logic [3:0] OP_XOR     = 4'b0101;
    localparam logic [3:0] OP_SUB     = 4'b0110;
    localparam logic [3:0] OP_SLT     = 4'b0111;
    localparam logic [3:0] OP_BEQ     = 4'b1000;
    localparam logic [3:0] OP_SLL     = 4'b1001;
    localparam logic [3:0] OP_BLT     = 4'b1010;
    localparam logic [3:0] OP_BGE     = 4'b1011;
    localparam logic [3:0] OP_ADD_IMM = 4'b1100;
    localparam logic [3:0] OP_SRL     = 4'b1101;
    localparam logic [3:0] OP_BNE     = 4'b1110;
    localparam logic [3:0] OP_NONE    = 4'b0000;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } md_state_t;

    function automatic logic is_signed_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative shift-add multiplier / restoring divider datapath
module muldiv_iter
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            step,
    input  md_op_t          op_in,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            special,
    output logic            last,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    md_op_t            op_q;
    logic              neg_a_q, neg_b_q;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     count;

    logic              is_div, sign_a, sign_b, neg_a, neg_b, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;

    always_comb begin
        is_div   = op_in[2];
        sign_a   = is_div ? is_signed_div(op_in) : (op_in == MD_MULH || op_in == MD_MULHSU);
        sign_b   = is_div ? is_signed_div(op_in) : (op_in == MD_MULH);
        neg_a    = sign_a & src_a[XLEN-1];
        neg_b    = sign_b & src_b[XLEN-1];
        mag_a    = neg_a ? -src_a : src_a;
        mag_b    = neg_b ? -src_b : src_b;
        div_zero = is_div && (src_b == '0);
        div_ovf  = is_signed_div(op_in) && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
        special  = div_zero | div_ovf;
        // op_in[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero)
            special_res = op_in[1] ? src_a : '1;
        else
            special_res = op_in[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    logic [XLEN:0]     sum, shifted, diff;
    logic [2*XLEN-1:0] acc_next, prod;
    logic [XLEN-1:0]   quot, rem, fixed;

    always_comb begin
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : '0)};
        shifted = acc[2*XLEN-1:XLEN-1];
        diff    = shifted - {1'b0, opnd};
        if (!op_q[2])
            acc_next = {sum, acc[XLEN-1:1]};
        else if (!diff[XLEN])
            acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_next = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};

        prod = (neg_a_q ^ neg_b_q) ? -acc_next : acc_next;
        quot = (neg_a_q ^ neg_b_q) ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem  = neg_a_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        if (op_q[2])
            fixed = op_q[1] ? rem : quot;
        else
            fixed = (op_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    assign last = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= MD_MUL;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            opnd    <= '0;
            acc     <= '0;
            count   <= '0;
            result  <= '0;
        end else if (start) begin
            op_q    <= op_in;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            opnd    <= is_div ? mag_b : mag_a;
            acc     <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            count   <= CW'(XLEN - 1);
            if (special)
                result <= special_res;
        end else if (step) begin
            acc   <= acc_next;
            count <= count - CW'(1);
            if (last)
                result <= fixed;
        end
    end

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// rtl/alu_muldiv_ctrl.sv - ALU operation decode plus M-extension sequencing and stall control
module alu_muldiv_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic            is_rtype,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            flush,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [3:0]      Operation,
    output logic            md_sel,
    output logic            stall,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);

    md_state_t state, state_next;
    logic      m_op, accept, step, special, last;

    assign m_op   = (ALUOp == 2'b10) && is_rtype && (Funct7 == FUNCT7_MULDIV);
    assign md_sel = m_op & valid_i;
    assign accept = (state == ST_IDLE) && valid_i && m_op && !flush;
    assign step   = (state == ST_CALC) && !flush;

    always_comb begin
        Operation = OP_NONE;
        case (ALUOp)
            2'b00: Operation = OP_ADD;
            2'b01: begin
                case (Funct3)
                    3'b000:  Operation = OP_BEQ;
                    3'b001:  Operation = OP_BNE;
                    3'b100:  Operation = OP_BLT;
                    3'b101:  Operation = OP_BGE;
                    default: Operation = OP_NONE;
                endcase
            end
            2'b10: begin
                if (m_op) begin
                    Operation = OP_ADD;
                end else begin
                    case (Funct3)
                        3'b000: begin
                            if (Funct7 == FUNCT7_BASE)     Operation = OP_ADD;
                            else if (Funct7 == FUNCT7_ALT) Operation = OP_SUB;
                            else                           Operation = OP_ADD_IMM;
                        end
                        3'b001: Operation = OP_SLL;
                        3'b010: Operation = OP_SLT;
                        3'b100: Operation = OP_XOR;
                        3'b101: begin
                            if (Funct7 == FUNCT7_BASE)     Operation = OP_SRL;
                            else if (Funct7 == FUNCT7_ALT) Operation = OP_SRA;
                            else                           Operation = OP_NONE;
                        end
                        3'b110: Operation = OP_OR;
                        3'b111: Operation = OP_AND;
                        default: Operation = OP_NONE;
                    endcase
                end
            end
            default: Operation = OP_NONE;
        endcase
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        md_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                stall = accept;
                if (accept)
                    state_next = special ? ST_DONE : ST_CALC;
            end
            ST_CALC: begin
                stall = !flush;
                if (last)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                md_done    = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // a killed op must never reach DONE
        if (flush)
            state_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk     (clk),
        .reset   (reset),
        .start   (accept),
        .step    (step),
        .op_in   (md_op_t'(Funct3)),
        .src_a   (src_a),
        .src_b   (src_b),
        .special (special),
        .last    (last),
        .result  (md_result)
    );

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// tb/tb_alu_muldiv_ctrl.sv - self-checking bench for alu_muldiv_ctrl
module tb_alu_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset, valid_i, is_rtype, flush, md_sel, stall, md_done;
    logic [1:0]  alu_op;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] src_a, src_b, md_result;
    logic [3:0]  operation;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    alu_muldiv_ctrl #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_i),
        .is_rtype  (is_rtype),
        .ALUOp     (alu_op),
        .Funct7    (funct7),
        .Funct3    (funct3),
        .flush     (flush),
        .src_a     (src_a),
        .src_b     (src_b),
        .Operation (operation),
        .md_sel    (md_sel),
        .stall     (stall),
        .md_done   (md_done),
        .md_result (md_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] aluop;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       rtype;
        logic [3:0] exp_op;
    } dec_vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } md_vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drive_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        valid_i  = 1'b1;
        is_rtype = 1'b1;
        alu_op   = 2'b10;
        funct7   = 7'b0000001;
        funct3   = f3;
        src_a    = a;
        src_b    = b;
        flush    = 1'b0;
    endtask

    // lat = cycles from acceptance to md_done, which equals the stall length
    task automatic run_md(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int  stalls = 0;
        int  cycles = 0;
        bit  seen = 0;
        logic [31:0] want;
        @(negedge clk);
        drive_md(f3, a, b);
        exp_q.push_back(exp);
        for (int c = 0; c < 100; c++) begin
            #1;
            if (md_done) begin
                seen = 1;
                cycles = c;
                break;
            end
            if (stall) stalls++;
            @(negedge clk);
        end
        check({name, " done_seen"}, 32'(seen), 32'd1);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        if (seen) begin
            check({name, " result"}, md_result, want);
            check({name, " stall_cycles"}, 32'(stalls), 32'(lat));
            check({name, " latency"}, 32'(cycles), 32'(lat));
            check({name, " stall_in_done"}, 32'(stall), 32'd0);
            check({name, " md_sel"}, 32'(md_sel), 32'd1);
        end
    endtask

    dec_vec_t dec_tab[16];
    md_vec_t  md_tab[14];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        dec_tab[0]  = '{2'b00, 7'h00, 3'b010, 1'b0, 4'b0010};
        dec_tab[1]  = '{2'b01, 7'h00, 3'b000, 1'b0, 4'b1000};
        dec_tab[2]  = '{2'b01, 7'h00, 3'b001, 1'b0, 4'b1110};
        dec_tab[3]  = '{2'b01, 7'h00, 3'b100, 1'b0, 4'b1010};
        dec_tab[4]  = '{2'b01, 7'h00, 3'b101, 1'b0, 4'b1011};
        dec_tab[5]  = '{2'b10, 7'h00, 3'b000, 1'b1, 4'b0010};
        dec_tab[6]  = '{2'b10, 7'h20, 3'b000, 1'b1, 4'b0110};
        dec_tab[7]  = '{2'b10, 7'h00, 3'b111, 1'b1, 4'b0000};
        dec_tab[8]  = '{2'b10, 7'h00, 3'b110, 1'b1, 4'b0001};
        dec_tab[9]  = '{2'b10, 7'h00, 3'b100, 1'b1, 4'b0101};
        dec_tab[10] = '{2'b10, 7'h00, 3'b010, 1'b0, 4'b0111};
        dec_tab[11] = '{2'b10, 7'h00, 3'b001, 1'b1, 4'b1001};
        dec_tab[12] = '{2'b10, 7'h00, 3'b101, 1'b1, 4'b1101};
        dec_tab[13] = '{2'b10, 7'h20, 3'b101, 1'b1, 4'b0100};
        dec_tab[14] = '{2'b10, 7'h01, 3'b000, 1'b0, 4'b1100};
        dec_tab[15] = '{2'b11, 7'h00, 3'b000, 1'b0, 4'b0000};

        md_tab[0]  = '{3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        md_tab[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        md_tab[2]  = '{3'b001, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 33};
        md_tab[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        md_tab[4]  = '{3'b100, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, 33};
        md_tab[5]  = '{3'b110, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 33};
        md_tab[6]  = '{3'b101, 32'd20,        32'd3,         32'd6,         33};
        md_tab[7]  = '{3'b111, 32'd20,        32'd3,         32'd2,         33};
        md_tab[8]  = '{3'b100, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 33};
        md_tab[9]  = '{3'b110, 32'd20,        32'hFFFF_FFFD, 32'd2,         33};
        md_tab[10] = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        md_tab[11] = '{3'b110, 32'd5,         32'd0,         32'd5,         1};
        md_tab[12] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        md_tab[13] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};

        reset = 1'b1; valid_i = 1'b0; is_rtype = 1'b0; flush = 1'b0;
        alu_op = 2'b00; funct7 = '0; funct3 = '0; src_a = '0; src_b = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset md_result", md_result, 32'd0);
        check("reset md_done", 32'(md_done), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        check("reset md_sel", 32'(md_sel), 32'd0);
        reset = 1'b0;

        foreach (dec_tab[i]) begin
            @(negedge clk);
            valid_i = 1'b1; flush = 1'b0;
            alu_op = dec_tab[i].aluop; funct7 = dec_tab[i].f7;
            funct3 = dec_tab[i].f3; is_rtype = dec_tab[i].rtype;
            #1;
            check($sformatf("dec[%0d] Operation", i), 32'(operation), 32'(dec_tab[i].exp_op));
            check($sformatf("dec[%0d] stall", i), 32'(stall), 32'd0);
            check($sformatf("dec[%0d] md_sel", i), 32'(md_sel), 32'd0);
        end

        // M op decodes to ADD but is not selected while EX is empty
        @(negedge clk);
        drive_md(3'b000, 32'd1, 32'd1);
        valid_i = 1'b0;
        #1;
        check("mop Operation", 32'(operation), 32'b0010);
        check("mop invalid md_sel", 32'(md_sel), 32'd0);
        check("mop invalid stall", 32'(stall), 32'd0);

        foreach (md_tab[i])
            run_md($sformatf("md[%0d]", i), md_tab[i].f3, md_tab[i].a, md_tab[i].b,
                   md_tab[i].exp, md_tab[i].lat);

        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, b;
            longint sa, sb, p;
            a = $urandom;
            b = $urandom | 32'd1;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p = sa * sb;
            run_md($sformatf("rnd[%0d] MUL", i), 3'b000, a, b, a * b, 33);
            run_md($sformatf("rnd[%0d] MULH", i), 3'b001, a, b, p[63:32], 33);
            run_md($sformatf("rnd[%0d] DIVU", i), 3'b101, a, b, a / b, 33);
            run_md($sformatf("rnd[%0d] REMU", i), 3'b111, a, b, a % b, 33);
        end

        // flush at CALC cycle 10 kills the op
        @(negedge clk);
        drive_md(3'b000, 32'd100, 32'd200);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush stall same cycle", 32'(stall), 32'd0);
        @(negedge clk);
        flush = 1'b0; valid_i = 1'b0;
        begin
            int done_cnt = 0;
            int stall_cnt = 0;
            for (int c = 0; c < 40; c++) begin
                #1;
                if (md_done) done_cnt++;
                if (stall) stall_cnt++;
                @(negedge clk);
            end
            check("flush no md_done", 32'(done_cnt), 32'd0);
            check("flush no stall after", 32'(stall_cnt), 32'd0);
        end
        run_md("post-flush MUL", 3'b000, 32'd2, 32'd3, 32'd6, 33);

        // reset mid-DIV
        @(negedge clk);
        drive_md(3'b100, 32'hFFFF_FFEC, 32'd3);
        repeat (5) @(negedge clk);
        reset = 1'b1; valid_i = 1'b0;
        @(negedge clk);
        #1;
        check("midreset md_result", md_result, 32'd0);
        check("midreset md_done", 32'(md_done), 32'd0);
        check("midreset stall", 32'(stall), 32'd0);
        reset = 1'b0;

        run_md("b2b MUL", 3'b000, 32'd12, 32'd11, 32'd132, 33);
        run_md("b2b DIV", 3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
        run_md("b2b DIVU0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_md("b2b MUL2", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33);

        @(negedge clk);
        valid_i = 1'b0;
        check("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_ctrl.md
# alu_muldiv_ctrl

ALU controller with an attached iterative M-extension multiply/divide engine for the EX stage. Decodes ALUOp/Funct3/Funct7 into the 4-bit ALU Operation code exactly as the base controller does. Additionally recognises RV32M instructions and runs them over multiple cycles, stalling the pipeline and returning the result on a dedicated port. Sits beside the ALU; the EX result mux selects `md_result` when `md_sel` is high.

## Interface
- `XLEN`, 32: operand/result width; iteration count equals XLEN.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  EX holds a valid instruction this cycle.
- `is_rtype`  in  1  opcode is OP (0110011), not OP-IMM; gates M decode.
- `ALUOp`  in  2  00 LW/SW/AUIPC, 01 branch, 10 R/I-type, 11 JAL/LUI.
- `Funct7`  in  7  instr[31:25].
- `Funct3`  in  3  instr[14:12].
- `flush`  in  1  kill the EX instruction.
- `src_a`, `src_b`  in  XLEN  rs1/rs2 operand values.
- `Operation`  out  4  ALU op code, combinational.
- `md_sel`  out  1  EX result comes from `md_result`.
- `stall`  out  1  hold PC/IF/ID/EX, combinational.
- `md_done`  out  1  `md_result` valid this cycle.
- `md_result`  out  XLEN  M-extension result, registered.

## Operation
- Base decode, combinational, unchanged codes: LW/SW 0010; BEQ 1000, BNE 1110, BLT 1010, BGE 1011; ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0101, SLT/SLTI 0111, SLL 1001, SRL 1101, SRA 0100; I-type f3=000 with Funct7 not 0000000/0100000 → 1100; ALUOp=11 or undefined → 0000.
- M op: `ALUOp`=10 & `is_rtype` & `Funct7`=0000001. Funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU. `Operation`=0010 (ALU result ignored). An OP-IMM with imm[11:5]=0000001 is never an M op.
- FSM states IDLE, CALC, DONE.
  - IDLE: `valid_i` & M op & !`flush` → accept. Latch op, operand magnitudes and sign flags. Special case → DONE, else CALC with count=XLEN-1.
  - CALC: one iteration per cycle (shift-add multiply over 2·XLEN accumulator; restoring divide, one quotient bit). count==0 → DONE, registering sign-corrected result.
  - DONE: `md_done`=1 → IDLE unconditionally; the held instruction is not re-accepted.
- Special cases (no iteration): divisor 0 → quotient all-ones, remainder = dividend; DIV/REM with dividend 0x8000_0000 and divisor −1 → quotient 0x8000_0000, remainder 0.
- Sign rules: MUL low half, sign-agnostic; MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned; quotient negated iff signs differ (signed ops); remainder takes dividend sign.
- `stall` = (IDLE & accept) | CALC; forced 0 when `flush`.
- `md_sel` = M op decoded & `valid_i`.
- `flush` in any state → IDLE next cycle; `md_done` not asserted for the killed op.

## Timing
- Reset: state IDLE, `md_result`=0, `md_done`=0, `stall`=0, count=0.
- Normal M op accepted at cycle 0: `stall` high in cycles 0..XLEN (XLEN+1 cycles). DONE, `md_done`=1 and `stall`=0 in cycle XLEN+1; the instruction retires from EX that cycle.
- Special case: `stall` high in cycle 0 only; DONE in cycle 1.
- Back-to-back M ops: second accepted in the cycle after DONE; no bubble beyond that.
- Reset mid-CALC aborts; outputs return to reset values the next cycle.
- Non-M instructions: zero added latency, `stall`=0.

## Structure
- Package `alu_ctrl_pkg`: localparams for all 4-bit Operation codes, `FUNCT7_MULDIV`=7'b0000001, `md_op_t` enum (Funct3 encoding), `md_state_t` enum.
- Sub-module `muldiv_iter`: datapath (operand/accumulator regs, counter, sign fix-up) with start/op/done. Top holds decode, FSM, stall/flush logic.

## Test plan
- Base decode sweep: SUB → 1100? no, SUB → 0110; BGE → 1011; ADDI imm 0x020 (Funct7=0000001, is_rtype=0) → 1100; in all cases `stall`=0, `md_sel`=0.
- MUL 7 × −3 → `stall` 33 cycles, then `md_done`, `md_result`=0xFFFF_FFEB; MULHU 0xFFFF_FFFF² → 0xFFFF_FFFE.
- DIV −20/3 → 0xFFFF_FFFA; REM −20/3 → 0xFFFF_FFFE; DIVU 20/3 → 6.
- DIVU 5/0 → 0xFFFF_FFFF; REM 5/0 → 5; DIV 0x8000_0000/−1 → 0x8000_0000; each with a 1-cycle stall.
- `flush` at CALC cycle 10 → `stall` drops the same cycle, IDLE next cycle, no `md_done`; a following MUL 2×3 → 6.
- `reset` asserted mid-DIV → all outputs 0 next cycle; back-to-back MUL then DIV both complete with correct results.
